fabric_config_loader: RTL and testbench

- Sequences the fabric configuration bitstream into the switch boxes and LUTs at power-up or on request.
- Replaces hierarchical testbench pokes with a real load path: accepts 32-bit words over a valid/ready stream and emits one write strobe per word with target element and word-select.
- Holds the fabric disabled until the whole stream plus a checksum word has been accepted and verified.
- Sits between the host/boot ROM reader and the fabric top.

---
 rtl/fabric_cfg_pkg.sv | 36 +++
 rtl/cfg_stream_cursor.sv | 55 +++++
 rtl/fabric_config_loader.sv | 125 ++++++++++++
 tb/tb_fabric_config_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// rtl/fabric_cfg_pkg.sv - shared types, sizes and element-kind table for the fabric config loader
package fabric_cfg_pkg;

   localparam int DATA_W    = 32;
   localparam int NUM_ELEMS = 35;
   localparam int NUM_WORDS = 57;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } state_t;

   localparam logic ELEM_SWITCH = 1'b0;
   localparam logic ELEM_LUT    = 1'b1;

   // One bit per element in stream order, set for LUTs:
   // 0-3 switch, 4-6 LUT, 7-10 switch, 11-29 LUT, 30-34 switch.
   localparam logic [NUM_ELEMS-1:0] ELEM_KIND_TABLE = 35'h0_3FFF_F870;

   function automatic logic elem_kind(input logic [5:0] idx);
      logic kind;
      kind = ELEM_SWITCH;
      if (idx < 6'(NUM_ELEMS)) begin
         kind = ELEM_KIND_TABLE[idx];
      end
      return kind;
   endfunction

   function automatic logic [1:0] words_per_elem(input logic kind);
      return (kind == ELEM_LUT) ? 2'd2 : 2'd1;
   endfunction

endpackage

// File: rtl/cfg_stream_cursor.sv
// rtl/cfg_stream_cursor.sv - tracks target element and word-select for each payload word
module cfg_stream_cursor
   import fabric_cfg_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clear_i,
   input  logic       adv_i,
   output logic [5:0] elem_idx_o,
   output logic       sub_o,
   output logic       last_o
);

   localparam logic [5:0] LAST_IDX = 6'(NUM_ELEMS - 1);

   logic [5:0] elem_idx_q, elem_idx_d;
   logic       sub_q, sub_d;
   logic       cur_kind;

   assign cur_kind = elem_kind(elem_idx_q);

   // Step to the next word slot: LUTs take two words, switch boxes one.
   always_comb begin
      elem_idx_d = elem_idx_q;
      sub_d      = sub_q;
      if (clear_i) begin
         elem_idx_d = '0;
         sub_d      = 1'b0;
      end else if (adv_i) begin
         if ((cur_kind == ELEM_LUT) && !sub_q) begin
            sub_d = 1'b1;
         end else begin
            sub_d      = 1'b0;
            elem_idx_d = elem_idx_q + 6'd1;
         end
      end
   end

   // Cursor registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         elem_idx_q <= '0;
         sub_q      <= 1'b0;
      end else begin
         elem_idx_q <= elem_idx_d;
         sub_q      <= sub_d;
      end
   end

   assign elem_idx_o = elem_idx_q;
   assign sub_o      = sub_q;
   assign last_o     = (elem_idx_q == LAST_IDX) &&
                       ({1'b0, sub_q} == (words_per_elem(cur_kind) - 2'd1));

endmodule

// File: rtl/fabric_config_loader.sv
// rtl/fabric_config_loader.sv - streams the config bitstream into the fabric and gates enable on checksum
module fabric_config_loader
   import fabric_cfg_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              cfg_we,
   output logic [5:0]        cfg_sel,
   output logic              cfg_word,
   output logic [DATA_W-1:0] cfg_data,
   output logic              fabric_en,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [5:0]        word_cnt
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic [5:0]        word_cnt_q, word_cnt_d;
   logic              cfg_we_q, cfg_we_d;
   logic [5:0]        cfg_sel_q, cfg_sel_d;
   logic              cfg_word_q, cfg_word_d;
   logic [DATA_W-1:0] cfg_data_q, cfg_data_d;

   logic              ready_w;
   logic              accept;
   logic              load_accept;
   logic [5:0]        elem_idx;
   logic              sub;
   logic              last_word;

   assign ready_w     = (state_q == ST_LOAD) || (state_q == ST_CHECK);
   // A start in the same cycle as a handshake drops the word.
   assign accept      = in_valid && ready_w && !start;
   assign load_accept = accept && (state_q == ST_LOAD);

   cfg_stream_cursor u_cursor (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear_i    (start),
      .adv_i      (load_accept),
      .elem_idx_o (elem_idx),
      .sub_o      (sub),
      .last_o     (last_word)
   );

   // Next-state, checksum accumulation and write-strobe staging.
   always_comb begin
      state_d    = state_q;
      sum_d      = sum_q;
      word_cnt_d = word_cnt_q;
      cfg_we_d   = 1'b0;
      cfg_sel_d  = cfg_sel_q;
      cfg_word_d = cfg_word_q;
      cfg_data_d = cfg_data_q;

      if (start) begin
         state_d    = ST_LOAD;
         sum_d      = '0;
         word_cnt_d = '0;
      end else begin
         unique case (state_q)
            ST_LOAD: begin
               if (accept) begin
                  cfg_we_d   = 1'b1;
                  cfg_sel_d  = elem_idx;
                  cfg_word_d = sub;
                  cfg_data_d = in_data;
                  sum_d      = sum_q + in_data;
                  word_cnt_d = word_cnt_q + 6'd1;
                  if (last_word) begin
                     state_d = ST_CHECK;
                  end
               end
            end
            ST_CHECK: begin
               if (accept) begin
                  state_d = (in_data == sum_q) ? ST_DONE : ST_ERROR;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // State and output registers; reset aborts any load in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         sum_q      <= '0;
         word_cnt_q <= '0;
         cfg_we_q   <= 1'b0;
         cfg_sel_q  <= '0;
         cfg_word_q <= 1'b0;
         cfg_data_q <= '0;
      end else begin
         state_q    <= state_d;
         sum_q      <= sum_d;
         word_cnt_q <= word_cnt_d;
         cfg_we_q   <= cfg_we_d;
         cfg_sel_q  <= cfg_sel_d;
         cfg_word_q <= cfg_word_d;
         cfg_data_q <= cfg_data_d;
      end
   end

   assign in_ready  = ready_w;
   assign busy      = ready_w;
   assign done      = (state_q == ST_DONE);
   assign error     = (state_q == ST_ERROR);
   assign fabric_en = (state_q == ST_DONE);
   assign cfg_we    = cfg_we_q;
   assign cfg_sel   = cfg_sel_q;
   assign cfg_word  = cfg_word_q;
   assign cfg_data  = cfg_data_q;
   assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_fabric_config_loader.sv
// tb/tb_fabric_config_loader.sv - randomized self-checking bench for fabric_config_loader
module tb_fabric_config_loader;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready, cfg_we, cfg_word, fabric_en, busy, done, error;
   logic [5:0]  cfg_sel, word_cnt;
   logic [31:0] cfg_data;

   always #5 clock = ~clock;

   fabric_config_loader dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .cfg_we    (cfg_we),
      .cfg_sel   (cfg_sel),
      .cfg_word  (cfg_word),
      .cfg_data  (cfg_data),
      .fabric_en (fabric_en),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .word_cnt  (word_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Word slot table: which element and word-select each payload word lands on.
   int slot_sel [0:56];
   int slot_sub [0:56];

   function automatic bit is_lut(input int e);
      return (e >= 4 && e <= 6) || (e >= 11 && e <= 29);
   endfunction

   // Behavioural model: phase 0 idle, 1 load, 2 check, 3 done, 4 error.
   int          m_phase = 0;
   int          m_n = 0;
   logic [31:0] m_sum = '0;
   logic        e_we = 1'b0;
   logic [5:0]  e_sel = '0;
   logic        e_sub = 1'b0;
   logic [31:0] e_data = '0;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_phase = 0;
         m_n     = 0;
         m_sum   = '0;
         e_we    = 1'b0;
      end else begin
         e_we = 1'b0;
         if (start) begin
            m_phase = 1;
            m_n     = 0;
            m_sum   = '0;
         end else if (in_valid && m_phase == 1) begin
            e_we   = 1'b1;
            e_sel  = 6'(slot_sel[m_n]);
            e_sub  = (slot_sub[m_n] != 0);
            e_data = in_data;
            m_sum  = m_sum + in_data;
            m_n++;
            if (m_n == 57) m_phase = 2;
         end else if (in_valid && m_phase == 2) begin
            m_phase = (in_data == m_sum) ? 3 : 4;
         end
      end
   end

   // Pulse log of observed writes, indexed by running pulse number.
   int          total_pulses = 0;
   int          cyc = 0;
   logic [5:0]  log_sel  [0:1023];
   logic        log_sub  [0:1023];
   logic [31:0] log_data [0:1023];
   int          log_cyc  [0:1023];

   // Per-cycle comparison against the model.
   always @(negedge clock) begin
      cyc++;
      chk("in_ready",  in_ready,  (m_phase == 1 || m_phase == 2));
      chk("busy",      busy,      (m_phase == 1 || m_phase == 2));
      chk("done",      done,      (m_phase == 3));
      chk("error",     error,     (m_phase == 4));
      chk("fabric_en", fabric_en, (m_phase == 3));
      chk("word_cnt",  word_cnt,  m_n);
      chk("cfg_we",    cfg_we,    e_we);
      if (e_we) begin
         chk("cfg_sel",  cfg_sel,  e_sel);
         chk("cfg_word", cfg_word, e_sub);
         chk("cfg_data", cfg_data, e_data);
      end
      if (cfg_we && total_pulses < 1024) begin
         log_sel[total_pulses]  = cfg_sel;
         log_sub[total_pulses]  = cfg_word;
         log_data[total_pulses] = cfg_data;
         log_cyc[total_pulses]  = cyc;
         total_pulses++;
      end
   end

   task automatic drive(input logic v, input logic [31:0] d, input logic s);
      @(negedge clock);
      #1;
      in_valid = v;
      in_data  = d;
      start    = s;
   endtask

   logic [31:0] exp_words [0:56];

   // Payload plus checksum, optionally with random idle gaps and random data.
   task automatic send_stream(input bit gaps, input bit bad, input bit rnd);
      logic [31:0] s;
      s = '0;
      for (int k = 0; k < 57; k++) begin
         exp_words[k] = rnd ? $urandom : 32'(k + 1);
         s = s + exp_words[k];
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) drive(1'b0, $urandom, 1'b0);
         end
         drive(1'b1, exp_words[k], 1'b0);
      end
      if (gaps) begin
         while ($urandom_range(0, 2) == 0) drive(1'b0, $urandom, 1'b0);
      end
      drive(1'b1, bad ? s - 32'd1 : s, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
   endtask

   int base;

   initial begin
      int k;
      k = 0;
      for (int e = 0; e < 35; e++) begin
         for (int w = 0; w < (is_lut(e) ? 2 : 1); w++) begin
            slot_sel[k] = e;
            slot_sub[k] = w;
            k++;
         end
      end
      chk("model_slot_total", k, 57);
      chk("model_slot5_sel", slot_sel[5], 4);
      chk("model_slot5_sub", slot_sub[5], 1);
      chk("model_slot10_sel", slot_sel[10], 7);
      chk("model_slot56_sel", slot_sel[56], 34);

      repeat (3) @(negedge clock);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_cfg_data", cfg_data, 0);
      chk("rst_cfg_sel", cfg_sel, 0);
      chk("rst_word_cnt", word_cnt, 0);
      chk("rst_fabric_en", fabric_en, 0);
      #1 reset_n = 1'b1;
      drive(1'b1, 32'h77, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      chk("idle_no_accept", word_cnt, 0);

      // Nominal load.
      drive(1'b0, 32'h0, 1'b1);
      base = total_pulses;
      send_stream(1'b0, 1'b0, 1'b0);
      chk("nom_pulses", total_pulses - base, 57);
      chk("nom_span", log_cyc[base + 56] - log_cyc[base], 56);
      chk("nom_w5_sel", log_sel[base + 5], 4);
      chk("nom_w5_sub", log_sub[base + 5], 1);
      chk("nom_w5_data", log_data[base + 5], 32'h6);
      chk("nom_w10_sel", log_sel[base + 10], 7);
      chk("nom_w10_sub", log_sub[base + 10], 0);
      chk("nom_w10_data", log_data[base + 10], 32'hB);
      chk("nom_w56_sel", log_sel[base + 56], 34);
      chk("nom_done", done, 1);
      chk("nom_fabric_en", fabric_en, 1);
      chk("nom_word_cnt", word_cnt, 57);

      // Bad checksum.
      drive(1'b0, 32'h0, 1'b1);
      base = total_pulses;
      send_stream(1'b0, 1'b1, 1'b0);
      chk("bad_pulses", total_pulses - base, 57);
      chk("bad_error", error, 1);
      chk("bad_done", done, 0);
      chk("bad_fabric_en", fabric_en, 0);

      // Random data with valid gaps.
      drive(1'b0, 32'h0, 1'b1);
      base = total_pulses;
      send_stream(1'b1, 1'b0, 1'b1);
      chk("gap_pulses", total_pulses - base, 57);
      for (int i = 0; i < 57; i++) begin
         if (log_data[base + i] !== exp_words[i] || log_sel[base + i] !== 6'(slot_sel[i]))
            chk("gap_order", log_data[base + i], exp_words[i]);
      end
      chk("gap_done", done, 1);

      // Restart mid-load with a coincident valid word.
      drive(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 20; i++) drive(1'b1, 32'(i + 1), 1'b0);
      drive(1'b1, 32'hDEAD, 1'b1);
      base = total_pulses;
      send_stream(1'b0, 1'b0, 1'b0);
      chk("rs_pulses", total_pulses - base, 57);
      chk("rs_first_sel", log_sel[base], 0);
      chk("rs_first_data", log_data[base], 32'h1);
      chk("rs_done", done, 1);

      // Reload after DONE.
      drive(1'b0, 32'h0, 1'b1);
      drive(1'b0, 32'h0, 1'b0);
      chk("rl_fabric_en", fabric_en, 0);
      chk("rl_busy", busy, 1);
      send_stream(1'b1, 1'b0, 1'b1);
      chk("rl_done", done, 1);

      // Asynchronous reset while waiting for the checksum.
      drive(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 57; i++) drive(1'b1, $urandom, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      chk("ar_in_check", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_in_ready", in_ready, 0);
      chk("ar_busy", busy, 0);
      chk("ar_cfg_we", cfg_we, 0);
      chk("ar_cfg_data", cfg_data, 0);
      chk("ar_cfg_sel", cfg_sel, 0);
      chk("ar_word_cnt", word_cnt, 0);
      chk("ar_done_err", {done, error, fabric_en}, 0);
      @(negedge clock);
      #2 reset_n = 1'b1;
      base = total_pulses;
      repeat (3) drive(1'b1, 32'h55, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      chk("ar_idle_ready", in_ready, 0);
      chk("ar_idle_cnt", word_cnt, 0);
      chk("ar_idle_pulses", total_pulses - base, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
